// File: rtl/wb_unit.sv
// Register-file writeback arbiter: ALU results win, LSU results queue in a FIFO,
// per-register busy scoreboard. Define WB_FWD_EN to add same-cycle forwarding outputs.
module wb_unit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    input  logic [4:0]               iss_rd_addr,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd_addr,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd_addr,
    input  logic [XLEN-1:0]          lsu_data,
    output logic                     rd_wen_o,
    output logic [4:0]               rd_addr_o,
    output logic [XLEN-1:0]          rd_data_o,
    input  logic [4:0]               rs1_addr_i,
    input  logic [4:0]               rs2_addr_i,
    output logic                     rs1_busy_o,
    output logic                     rs2_busy_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o
`ifdef WB_FWD_EN
    ,
    output logic                     rs1_fwd_o,
    output logic                     rs2_fwd_o,
    output logic [XLEN-1:0]          fwd_data_o
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_data [DEPTH];
    logic [4:0]      mem_addr [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     cnt;
    logic [31:0]     busy;

    logic alu_wr, push, pop;
    logic [31:0] set_mask, clr_mask;
    logic match1, match2;

    assign lsu_ready  = (cnt != (AW+1)'(DEPTH));
    assign fifo_cnt_o = cnt;
    // Address-0 ALU results are dropped and leave the port free for a FIFO drain.
    assign alu_wr = alu_valid && (alu_rd_addr != 5'd0);
    assign push   = lsu_valid && lsu_ready && (lsu_rd_addr != 5'd0);
    assign pop    = !alu_wr && (cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= lsu_data;
            mem_addr[wr_ptr] <= lsu_rd_addr;
        end
    end

    // Write port stage: address/data hold when no write is selected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_wen_o  <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            rd_wen_o <= alu_wr || pop;
            if (alu_wr) begin
                rd_addr_o <= alu_rd_addr;
                rd_data_o <= alu_data;
            end else if (pop) begin
                rd_addr_o <= mem_addr[rd_ptr];
                rd_data_o <= mem_data[rd_ptr];
            end
        end
    end

    // Bit 0 is never set, so x0 never reads as busy.
    assign set_mask = (iss_valid && iss_rd_addr != 5'd0) ? (32'd1 << iss_rd_addr) : 32'd0;
    assign clr_mask = rd_wen_o ? (32'd1 << rd_addr_o) : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= (busy & ~clr_mask) | set_mask;
    end

    assign match1 = rd_wen_o && (rd_addr_o == rs1_addr_i) && (rs1_addr_i != 5'd0);
    assign match2 = rd_wen_o && (rd_addr_o == rs2_addr_i) && (rs2_addr_i != 5'd0);

`ifdef WB_FWD_EN
    // A committing write is forwarded, so the register is treated as already free.
    assign rs1_busy_o = (rs1_addr_i != 5'd0) && busy[rs1_addr_i] && !match1;
    assign rs2_busy_o = (rs2_addr_i != 5'd0) && busy[rs2_addr_i] && !match2;
    assign rs1_fwd_o  = match1;
    assign rs2_fwd_o  = match2;
    assign fwd_data_o = rd_data_o;
`else
    assign rs1_busy_o = (rs1_addr_i != 5'd0) && (busy[rs1_addr_i] || match1);
    assign rs2_busy_o = (rs2_addr_i != 5'd0) && (busy[rs2_addr_i] || match2);
`endif
endmodule
